// File: rtl/rsa_pkg.sv
// Shared definitions for the rsa block: controller state encoding and the
// default operand / exponent widths used by the top and its helpers.
package rsa_pkg;

    localparam int WIDTH_DEF   = 1024;
    localparam int E_WIDTH_DEF = 1024;
    localparam int LEN_W_DEF   = 11;

    typedef enum logic [2:0] {
        IDLE,
        TOMONT,
        SQ,
        MUL,
        FROMMONT,
        DONE
    } state_t;

endpackage

// File: rtl/rsa_cond_sub.sv
// Conditional final subtraction: folds a multiplier output (< 2N) back into
// [0, N).
// Ports:
//   x  in  WIDTH+1  value to reduce, assumed < 2N
//   n  in  WIDTH    modulus
//   y  out WIDTH    x mod N
module rsa_cond_sub #(
    parameter int WIDTH = 1024
) (
    input  logic [WIDTH:0]   x,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH:0] n_ext;
    logic [WIDTH:0] diff;

    assign n_ext = {1'b0, n};
    assign diff  = x - n_ext;
    assign y     = (x >= n_ext) ? diff[WIDTH-1:0] : x[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Montgomery-domain modular exponentiation controller: result = base^exp mod N.
// Scans the exponent MSB-first (square-and-multiply) and sequences an external
// Montgomery multiplier; one start runs the whole exponentiation.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   start, abort                begin (1-cycle pulse) / cancel in-flight run
//   base, modulus, r_n, r2_n    operands (A, N, R mod N, R^2 mod N)
//   exponent, exp_len           exponent and number of bits to scan
//   busy, done, error, result   status and result (result holds until next done)
//   mm_ops                      multiplications issued in current/last run
//   mm_start, mm_a, mm_b, mm_m  multiplier request
//   mm_result, mm_done          multiplier response
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int E_WIDTH = E_WIDTH_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   base,
    input  logic [WIDTH-1:0]   modulus,
    input  logic [WIDTH-1:0]   r_n,
    input  logic [WIDTH-1:0]   r2_n,
    input  logic [E_WIDTH-1:0] exponent,
    input  logic [LEN_W-1:0]   exp_len,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [WIDTH-1:0]   result,
    output logic [15:0]        mm_ops,
    output logic               mm_start,
    output logic [WIDTH-1:0]   mm_a,
    output logic [WIDTH-1:0]   mm_b,
    output logic [WIDTH-1:0]   mm_m,
    input  logic [WIDTH:0]     mm_result,
    input  logic               mm_done
);

    state_t             state, state_nx;
    logic [WIDTH-1:0]   base_q, rn_q, r2_q;
    logic [E_WIDTH-1:0] e_q, e_sh;
    logic [LEN_W-1:0]   len_q, idx;
    logic [WIDTH-1:0]   at, xt, red;
    logic               issued;
    logic               waiting, mm_ack, ebit, idx_zero, len_bad, go;

    rsa_cond_sub #(.WIDTH(WIDTH)) u_red (
        .x (mm_result),
        .n (mm_m),
        .y (red)
    );

    // Responses are only taken once the request pulse has gone out, so a stale
    // mm_done from an aborted run cannot land on the issue cycle.
    assign waiting  = issued && !mm_start;
    assign mm_ack   = waiting && mm_done;
    assign e_sh     = e_q >> idx;
    assign ebit     = e_sh[0];
    assign idx_zero = (idx == '0);
    assign len_bad  = (exp_len > LEN_W'(E_WIDTH));
    assign go       = (state == IDLE) && start && !abort;
    assign busy     = (state == TOMONT) || (state == SQ) || (state == MUL) || (state == FROMMONT);
    assign done     = (state == DONE);

    always_comb begin
        state_nx = state;
        mm_a     = '0;
        mm_b     = '0;
        case (state)
            IDLE:     if (go && !len_bad) state_nx = TOMONT;
            TOMONT: begin
                mm_a = base_q;
                mm_b = r2_q;
                if (mm_ack) state_nx = (len_q == '0) ? FROMMONT : SQ;
            end
            SQ: begin
                mm_a = at;
                mm_b = at;
                if (mm_ack) state_nx = ebit ? MUL : (idx_zero ? FROMMONT : SQ);
            end
            MUL: begin
                mm_a = at;
                mm_b = xt;
                if (mm_ack) state_nx = idx_zero ? FROMMONT : SQ;
            end
            FROMMONT: begin
                mm_a = at;
                mm_b = WIDTH'(1);
                if (mm_ack) state_nx = DONE;
            end
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (abort && busy) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            base_q   <= '0;
            mm_m     <= '0;
            rn_q     <= '0;
            r2_q     <= '0;
            e_q      <= '0;
            len_q    <= '0;
            idx      <= '0;
            at       <= '0;
            xt       <= '0;
            issued   <= 1'b0;
            mm_start <= 1'b0;
            mm_ops   <= '0;
            result   <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_nx;
            error    <= 1'b0;
            mm_start <= 1'b0;
            if (go) begin
                base_q <= base;
                mm_m   <= modulus;
                rn_q   <= r_n;
                r2_q   <= r2_n;
                e_q    <= exponent;
                len_q  <= exp_len;
                issued <= 1'b0;
                if (len_bad) error  <= 1'b1;
                else         mm_ops <= '0;
            end
            if (abort && busy) begin
                issued <= 1'b0;
            end else if (busy) begin
                if (!issued) begin
                    // issue sub-phase: one request per visit of an mm state
                    mm_start <= 1'b1;
                    issued   <= 1'b1;
                    mm_ops   <= mm_ops + 16'd1;
                    if (state == TOMONT) begin
                        at  <= rn_q;
                        idx <= len_q - 1'b1;
                    end
                end else if (mm_ack) begin
                    issued <= 1'b0;
                    case (state)
                        TOMONT:   xt <= red;
                        SQ: begin
                            at <= red;
                            if (!ebit && !idx_zero) idx <= idx - 1'b1;
                        end
                        MUL: begin
                            at <= red;
                            if (!idx_zero) idx <= idx - 1'b1;
                        end
                        FROMMONT: result <= red;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
module tb_rsa_modexp_ctrl;

    localparam int W  = 8;
    localparam int EW = 8;
    localparam int LW = 4;
    localparam int N  = 239;
    localparam int R  = 256;

    logic          clk = 0;
    logic          resetn = 0;
    logic          start = 0, abort = 0;
    logic [W-1:0]  base = 0, modulus = N, r_n = 17, r2_n = 50;
    logic [EW-1:0] exponent = 0;
    logic [LW-1:0] exp_len = 0;
    logic          busy, done, error, mm_start, mm_done = 0;
    logic [W-1:0]  result, mm_a, mm_b, mm_m;
    logic [15:0]   mm_ops;
    logic [W:0]    mm_result = 0;

    rsa_modexp_ctrl #(.WIDTH(W), .E_WIDTH(EW), .LEN_W(LW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .base(base), .modulus(modulus), .r_n(r_n), .r2_n(r2_n),
        .exponent(exponent), .exp_len(exp_len),
        .busy(busy), .done(done), .error(error), .result(result), .mm_ops(mm_ops),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int res;
        int ops;
    } exp_t;

    exp_t sb[$];
    int total = 0, bad = 0;
    int pulses = 0, completions = 0;
    int rinv = 0;
    int last_res = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // plain repeated multiplication, independent of any bit scanning
    function automatic int ref_pow(int b, int e);
        int r = 1 % N;
        for (int k = 0; k < e; k++) r = (r * b) % N;
        return r;
    endfunction

    // behavioural Montgomery multiplier, 5-cycle latency, output sometimes in [N, 2N)
    initial begin
        int a, b, r;
        forever begin
            @(negedge clk);
            if (mm_start) begin
                a = int'(mm_a);
                b = int'(mm_b);
                repeat (5) @(posedge clk);
                #1;
                r = (a * b * rinv) % N;
                if ($urandom_range(0, 1) == 1) r += N;
                mm_result = (W+1)'(r);
                mm_done = 1;
                @(posedge clk);
                #1 mm_done = 0;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (mm_start) pulses++;
            if (done || error) begin
                completions++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output done=%0b error=%0b required none", done, error);
                end else begin
                    e = sb.pop_front();
                    chk("error_vs_done", error, e.is_err);
                    if (!e.is_err) begin
                        chk("result", result, e.res);
                        chk("mm_ops", mm_ops, e.ops);
                        chk("mm_start_pulses", pulses, e.ops);
                        chk("busy_at_done", busy, 0);
                    end
                end
            end
        end
    end

    task automatic issue(int b, int e, int len, bit push);
        exp_t x;
        int eff;
        @(posedge clk);
        #1;
        base = W'(b);
        exponent = EW'(e);
        exp_len = LW'(len);
        start = 1;
        pulses = 0;
        if (push) begin
            x.is_err = (len > EW);
            eff = (len > EW) ? 0 : (e & ((1 << len) - 1));
            x.res = ref_pow(b, eff);
            x.ops = 2 + len + $countones(eff);
            sb.push_back(x);
            if (!x.is_err) last_res = x.res;
        end
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_cnt(int target);
        int n = 0;
        while (completions < target && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (completions < target) begin
            total++;
            bad++;
            $display("FAIL timeout completions=%0d required=%0d", completions, target);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int c0, n, saved;
        for (int x = 1; x < N; x++) if ((R * x) % N == 1) rinv = x;

        // reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_result", result, 0);
        chk("rst_mm_start", mm_start, 0);
        chk("rst_mm_ops", mm_ops, 0);
        chk("rst_mm_m", mm_m, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1;

        // 1. basic, with busy rising the cycle after start
        issue(5, 3, 2, 1);
        chk("busy_after_start", busy, 1);
        wait_cnt(1);
        // 2. exp_len = 0
        issue(5, 3, 0, 1);
        wait_cnt(2);
        // 3. all-ones exponent, full length
        issue(200, 8'hFF, 8, 1);
        wait_cnt(3);

        // 4. exp_len out of range
        issue(5, 3, 9, 1);
        chk("error_pulse", error, 1);
        chk("error_busy", busy, 0);
        repeat (10) @(posedge clk);
        chk("error_no_mm_start", pulses, 0);
        chk("error_busy_later", busy, 0);
        wait_cnt(4);

        // 5. abort during the 3rd multiplier wait
        saved = last_res;
        issue(7, 8'hA5, 8, 0);
        n = 0;
        while (pulses < 3 && n < 200) begin @(posedge clk); n++; end
        chk("abort_reached_3rd_op", pulses, 3);
        repeat (2) @(posedge clk);
        #1 abort = 1;
        @(posedge clk);
        #1 abort = 0;
        chk("abort_busy", busy, 0);
        c0 = completions;
        repeat (12) @(posedge clk);
        chk("abort_result_kept", result, saved);
        chk("abort_no_done", completions, c0);
        issue(9, 8'h6D, 7, 1);
        wait_cnt(5);

        // 6. start while busy is ignored
        issue(5, 3, 2, 1);
        repeat (8) @(posedge clk);
        #1;
        base = 77; exponent = 8'hF0; exp_len = 8; start = 1;
        @(posedge clk);
        #1 start = 0;
        wait_cnt(6);

        // randomized runs
        for (int i = 0; i < 10; i++) begin
            issue($urandom_range(0, N-1), $urandom_range(0, 255), $urandom_range(0, 8), 1);
            wait_cnt(7 + i);
        end

        // reset mid-run clears outputs immediately
        issue(123, 8'hC3, 8, 0);
        repeat (15) @(posedge clk);
        #1 resetn = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_mm_start", mm_start, 0);
        chk("midrst_mm_ops", mm_ops, 0);
        chk("midrst_mm_a", mm_a, 0);
        chk("midrst_mm_m", mm_m, 0);
        repeat (12) @(posedge clk);
        #1 resetn = 1;
        issue(3, 8'h11, 5, 1);
        wait_cnt(17);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
